// File: rtl/pfifo_pkg.sv
// Shared types and sizing for the 6-bit-symbol packing FIFO scheduler.
package pfifo_pkg;

    localparam int SYM_W   = 6;
    localparam int MAX_SYM = 16;
    localparam int CAP_SYM = 48;
    localparam int DATA_W  = SYM_W * MAX_SYM;

    typedef logic [3:0] amt_t;
    typedef logic [5:0] occ_t;
    typedef logic [6:0] wide_t;

    typedef enum logic [1:0] {
        S_RUN,
        S_FLUSH,
        S_DONE
    } sched_state_t;

    // Amount fields carry N-1; widen to a symbol count for 7-bit arithmetic.
    function automatic wide_t amtToSyms(input amt_t amt);
        return {3'b000, amt} + 7'd1;
    endfunction

endpackage

// File: rtl/pfifo_rr_arb2.sv
// Two-way round-robin arbiter; priority flips to the other requester only when adv confirms a grant.
module pfifo_rr_arb2 (
    input  logic       i_core_clk,
    input  logic       i_rx_rstn,
    input  logic [1:0] req,
    input  logic       adv,
    output logic [1:0] gnt
);

    logic prioP1;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = prioP1 ? 2'b10 : 2'b01;
        end
    end

    // After granting p0 the pointer favours p1, and vice versa.
    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
        if (!i_rx_rstn) begin
            prioP1 <= 1'b0;
        end else if (adv) begin
            prioP1 <= gnt[0];
        end
    end

endmodule

// File: rtl/pfifo_join_pop_sched.sv
// Join/pop scheduler for the packing FIFO: arbitration, occupancy tracking and flush drain.
// Optional watermark outputs are enabled with `define PFIFO_SCHED_WMARK_EN.
module pfifo_join_pop_sched
    import pfifo_pkg::*;
`ifdef PFIFO_SCHED_WMARK_EN
#(
    parameter int AF_LVL = 40,
    parameter int AE_LVL = 8
)
`endif
(
    input  logic              i_core_clk,
    input  logic              i_rx_rstn,
    input  logic              i_p0_req,
    input  logic [3:0]        i_p0_amt,
    input  logic [DATA_W-1:0] i_p0_data,
    output logic              o_p0_gnt,
    input  logic              i_p1_req,
    input  logic [3:0]        i_p1_amt,
    input  logic [DATA_W-1:0] i_p1_data,
    output logic              o_p1_gnt,
    input  logic              i_pop_req,
    input  logic [3:0]        i_pop_amt,
    output logic              o_pop_gnt,
    input  logic              i_flush,
    output logic              o_flush_done,
    output logic              o_join_en,
    output logic [3:0]        o_join_amt,
    output logic [DATA_W-1:0] o_join_data,
    output logic              o_pop_en,
    output logic [3:0]        o_pop_amt,
    output logic [5:0]        o_occ
`ifdef PFIFO_SCHED_WMARK_EN
    ,
    output logic              o_almost_full,
    output logic              o_almost_empty
`endif
);

    sched_state_t      state;
    sched_state_t      stateNext;
    occ_t              occ;
    wide_t             occWide;
    wide_t             occSum;
    wide_t             popSyms;
    wide_t             joinSyms;
    wide_t             drainSyms;
    logic [1:0]        arbReq;
    logic [1:0]        arbGnt;
    amt_t              winAmt;
    logic [DATA_W-1:0] winData;
    logic              runOk;
    logic              spaceOk;
    logic              popGnt;
    logic              joinGnt;
    logic              drainPop;

    assign arbReq = {i_p1_req, i_p0_req};

    pfifo_rr_arb2 uArb (
        .i_core_clk (i_core_clk),
        .i_rx_rstn  (i_rx_rstn),
        .req        (arbReq),
        .adv        (joinGnt),
        .gnt        (arbGnt)
    );

    // A flush request takes precedence over any grant in the cycle it arrives.
    always_comb begin
        runOk     = i_rx_rstn && (state == S_RUN) && !i_flush;
        occWide   = {1'b0, occ};
        popSyms   = amtToSyms(i_pop_amt);
        popGnt    = runOk && i_pop_req && (occWide >= popSyms);
        winAmt    = arbGnt[1] ? i_p1_amt : i_p0_amt;
        winData   = arbGnt[1] ? i_p1_data : i_p0_data;
        joinSyms  = amtToSyms(winAmt);
        spaceOk   = (occWide + joinSyms) <= (wide_t'(CAP_SYM) + (popGnt ? popSyms : 7'd0));
`ifdef PFIFO_SCHED_WMARK_EN
        if (o_almost_full && (joinSyms > (wide_t'(CAP_SYM) - occWide))) begin
            spaceOk = 1'b0;
        end
`endif
        joinGnt   = runOk && (|arbGnt) && spaceOk;
        drainPop  = (state == S_FLUSH) && (occ != '0);
        drainSyms = (occWide > wide_t'(MAX_SYM)) ? wide_t'(MAX_SYM) : occWide;
        occSum    = occWide
                  + (joinGnt  ? joinSyms  : 7'd0)
                  - (popGnt   ? popSyms   : 7'd0)
                  - (drainPop ? drainSyms : 7'd0);
    end

    assign o_p0_gnt     = joinGnt && arbGnt[0];
    assign o_p1_gnt     = joinGnt && arbGnt[1];
    assign o_pop_gnt    = popGnt;
    assign o_flush_done = (state == S_DONE);
    assign o_occ        = occ;

    always_comb begin
        stateNext = state;
        case (state)
            S_RUN:   if (i_flush) stateNext = S_FLUSH;
            S_FLUSH: if (occ == '0) stateNext = S_DONE;
            S_DONE:  stateNext = S_RUN;
            default: stateNext = S_RUN;
        endcase
    end

    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
        if (!i_rx_rstn) begin
            state <= S_RUN;
        end else begin
            state <= stateNext;
        end
    end

    // FIFO commands are registered, so they land one cycle after the grant.
    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
        if (!i_rx_rstn) begin
            occ         <= '0;
            o_join_en   <= 1'b0;
            o_join_amt  <= '0;
            o_join_data <= '0;
            o_pop_en    <= 1'b0;
            o_pop_amt   <= '0;
        end else begin
            occ         <= occ_t'(occSum);
            o_join_en   <= joinGnt;
            o_join_amt  <= joinGnt ? winAmt : '0;
            o_join_data <= joinGnt ? winData : '0;
            o_pop_en    <= popGnt || drainPop;
            if (popGnt) begin
                o_pop_amt <= i_pop_amt;
            end else if (drainPop) begin
                o_pop_amt <= amt_t'(drainSyms - 7'd1);
            end else begin
                o_pop_amt <= '0;
            end
        end
    end

`ifdef PFIFO_SCHED_WMARK_EN
    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
        if (!i_rx_rstn) begin
            o_almost_full  <= 1'b0;
            o_almost_empty <= 1'b1;
        end else begin
            o_almost_full  <= int'(occSum) >= AF_LVL;
            o_almost_empty <= int'(occSum) <= AE_LVL;
        end
    end
`endif

    occNeverOverCap : assert property (@(posedge i_core_clk) disable iff (!i_rx_rstn)
        occ <= occ_t'(CAP_SYM));

    popNeverUnderflows : assert property (@(posedge i_core_clk) disable iff (!i_rx_rstn)
        (popGnt || drainPop) |-> ((popGnt ? popSyms : drainSyms) <= occWide));

endmodule

// File: tb/tb_pfifo_join_pop_sched.sv
// Bench for pfifo_join_pop_sched: directed vector table, reset sequences and a randomized run
// against a behavioural occupancy/arbitration model.
module tb_pfifo_join_pop_sched;
    import pfifo_pkg::*;

    typedef struct {
        bit       p0Req;
        bit [3:0] p0Amt;
        bit       p1Req;
        bit [3:0] p1Amt;
        bit       popReq;
        bit [3:0] popAmt;
        bit       flush;
        bit       expP0Gnt;
        bit       expP1Gnt;
        bit       expPopGnt;
        bit       expDone;
        bit       expJoinEn;
        bit       expPopEn;
        bit [3:0] expPopAmt;
        int       expOcc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        p0Req = 1'b0, p1Req = 1'b0, popReq = 1'b0, flush = 1'b0;
    logic [3:0]  p0Amt = '0, p1Amt = '0, popAmt = '0;
    logic [95:0] p0Data = '0, p1Data = '0;
    logic        p0Gnt, p1Gnt, popGnt, flushDone, joinEn, popEn;
    logic [3:0]  joinAmt, popAmtOut;
    logic [95:0] joinData;
    logic [5:0]  occ;
`ifdef PFIFO_SCHED_WMARK_EN
    logic        almostFull, almostEmpty;
`endif

    int checkCount = 0;
    int passCount  = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    pfifo_join_pop_sched dut (
        .i_core_clk   (clk),
        .i_rx_rstn    (rstn),
        .i_p0_req     (p0Req),
        .i_p0_amt     (p0Amt),
        .i_p0_data    (p0Data),
        .o_p0_gnt     (p0Gnt),
        .i_p1_req     (p1Req),
        .i_p1_amt     (p1Amt),
        .i_p1_data    (p1Data),
        .o_p1_gnt     (p1Gnt),
        .i_pop_req    (popReq),
        .i_pop_amt    (popAmt),
        .o_pop_gnt    (popGnt),
        .i_flush      (flush),
        .o_flush_done (flushDone),
        .o_join_en    (joinEn),
        .o_join_amt   (joinAmt),
        .o_join_data  (joinData),
        .o_pop_en     (popEn),
        .o_pop_amt    (popAmtOut),
        .o_occ        (occ)
`ifdef PFIFO_SCHED_WMARK_EN
        ,
        .o_almost_full  (almostFull),
        .o_almost_empty (almostEmpty)
`endif
    );

    task automatic checkOutput(input string name, input logic [95:0] actual, input logic [95:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic vec_t mkVec(bit p0r, int p0a, bit p1r, int p1a, bit popr, int popa, bit fl,
                                   bit eP0, bit eP1, bit ePop, bit eDone,
                                   bit eJe, bit ePe, int ePa, int eOcc);
        vec_t v;
        v.p0Req = p0r;   v.p0Amt = 4'(p0a);
        v.p1Req = p1r;   v.p1Amt = 4'(p1a);
        v.popReq = popr; v.popAmt = 4'(popa);
        v.flush = fl;
        v.expP0Gnt = eP0; v.expP1Gnt = eP1; v.expPopGnt = ePop; v.expDone = eDone;
        v.expJoinEn = eJe; v.expPopEn = ePe; v.expPopAmt = 4'(ePa); v.expOcc = eOcc;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        p0Req  = v.p0Req;  p0Amt = v.p0Amt;
        p1Req  = v.p1Req;  p1Amt = v.p1Amt;
        popReq = v.popReq; popAmt = v.popAmt;
        flush  = v.flush;
        p0Data = {$urandom, $urandom, $urandom};
        p1Data = {$urandom, $urandom, $urandom};
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " p0Gnt"}, 96'(p0Gnt), 96'(0));
        checkOutput({tag, " p1Gnt"}, 96'(p1Gnt), 96'(0));
        checkOutput({tag, " popGnt"}, 96'(popGnt), 96'(0));
        checkOutput({tag, " flushDone"}, 96'(flushDone), 96'(0));
        checkOutput({tag, " joinEn"}, 96'(joinEn), 96'(0));
        checkOutput({tag, " joinData"}, joinData, 96'(0));
        checkOutput({tag, " popEn"}, 96'(popEn), 96'(0));
        checkOutput({tag, " occ"}, 96'(occ), 96'(0));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [95:0] expData;
        logic [3:0]  expJoinAmt;
        int mOcc, mLast, mPhase;

        // Reset with a producer already requesting: nothing may be granted.
        p0Req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        rstn  = 1'b1;
        p0Req = 1'b0;

        // Directed sequence: alternation, full store, pop-funds-join, same-cycle join+pop,
        // pre-join occupancy pop check, flush of 37 and flush with an empty store.
        vecs.push_back(mkVec(1,3,1,3,0,0,0,  1,0,0,0, 1,0,0,4));
        vecs.push_back(mkVec(1,3,1,3,0,0,0,  0,1,0,0, 1,0,0,8));
        vecs.push_back(mkVec(1,3,1,3,0,0,0,  1,0,0,0, 1,0,0,12));
        vecs.push_back(mkVec(1,3,1,3,0,0,0,  0,1,0,0, 1,0,0,16));
        vecs.push_back(mkVec(1,15,0,0,0,0,0, 1,0,0,0, 1,0,0,32));
        vecs.push_back(mkVec(1,15,0,0,0,0,0, 1,0,0,0, 1,0,0,48));
        vecs.push_back(mkVec(1,0,0,0,0,0,0,  0,0,0,0, 0,0,0,48));
        vecs.push_back(mkVec(1,0,0,0,0,0,0,  0,0,0,0, 0,0,0,48));
        vecs.push_back(mkVec(1,0,0,0,1,0,0,  1,0,1,0, 1,1,0,48));
        vecs.push_back(mkVec(1,15,0,0,1,15,0,1,0,1,0, 1,1,15,48));
        vecs.push_back(mkVec(0,0,0,0,1,15,0, 0,0,1,0, 0,1,15,32));
        vecs.push_back(mkVec(0,0,0,0,1,15,0, 0,0,1,0, 0,1,15,16));
        vecs.push_back(mkVec(0,0,0,0,1,10,0, 0,0,1,0, 0,1,10,5));
        vecs.push_back(mkVec(1,3,0,0,1,7,0,  1,0,0,0, 1,0,0,9));
        vecs.push_back(mkVec(0,0,0,0,1,7,0,  0,0,1,0, 0,1,7,1));
        vecs.push_back(mkVec(0,0,1,15,0,0,0, 0,1,0,0, 1,0,0,17));
        vecs.push_back(mkVec(0,0,1,15,0,0,0, 0,1,0,0, 1,0,0,33));
        vecs.push_back(mkVec(1,3,0,0,0,0,0,  1,0,0,0, 1,0,0,37));
        vecs.push_back(mkVec(1,3,1,3,0,0,1,  0,0,0,0, 0,0,0,37));
        vecs.push_back(mkVec(1,3,1,3,1,0,0,  0,0,0,0, 0,1,15,21));
        vecs.push_back(mkVec(1,3,1,3,1,0,1,  0,0,0,0, 0,1,15,5));
        vecs.push_back(mkVec(1,3,1,3,1,0,0,  0,0,0,0, 0,1,4,0));
        vecs.push_back(mkVec(1,3,1,3,1,0,0,  0,0,0,0, 0,0,0,0));
        vecs.push_back(mkVec(1,3,1,3,1,0,1,  0,0,0,1, 0,0,0,0));
        vecs.push_back(mkVec(1,3,1,3,0,0,0,  0,1,0,0, 1,0,0,4));
        vecs.push_back(mkVec(0,0,0,0,1,3,0,  0,0,1,0, 0,1,3,0));
        vecs.push_back(mkVec(0,0,0,0,0,0,1,  0,0,0,0, 0,0,0,0));
        vecs.push_back(mkVec(0,0,0,0,0,0,0,  0,0,0,0, 0,0,0,0));
        vecs.push_back(mkVec(0,0,0,0,0,0,0,  0,0,0,1, 0,0,0,0));
        vecs.push_back(mkVec(0,0,0,0,0,0,0,  0,0,0,0, 0,0,0,0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput($sformatf("vec%0d p0Gnt", i), 96'(p0Gnt), 96'(vecs[i].expP0Gnt));
            checkOutput($sformatf("vec%0d p1Gnt", i), 96'(p1Gnt), 96'(vecs[i].expP1Gnt));
            checkOutput($sformatf("vec%0d popGnt", i), 96'(popGnt), 96'(vecs[i].expPopGnt));
            checkOutput($sformatf("vec%0d flushDone", i), 96'(flushDone), 96'(vecs[i].expDone));
            expData    = vecs[i].expP0Gnt ? p0Data : (vecs[i].expP1Gnt ? p1Data : '0);
            expJoinAmt = vecs[i].expP0Gnt ? vecs[i].p0Amt : (vecs[i].expP1Gnt ? vecs[i].p1Amt : 4'd0);
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d joinEn", i), 96'(joinEn), 96'(vecs[i].expJoinEn));
            checkOutput($sformatf("vec%0d joinAmt", i), 96'(joinAmt), 96'(expJoinAmt));
            checkOutput($sformatf("vec%0d joinData", i), joinData, expData);
            checkOutput($sformatf("vec%0d popEn", i), 96'(popEn), 96'(vecs[i].expPopEn));
            checkOutput($sformatf("vec%0d popAmt", i), 96'(popAmtOut), 96'(vecs[i].expPopAmt));
            checkOutput($sformatf("vec%0d occ", i), 96'(occ), 96'(vecs[i].expOcc));
        end

        // Reset mid-traffic: p0 granted last, so a surviving pointer would favour p1 after release.
        p0Req = 1'b1; p0Amt = 4'd5; p1Req = 1'b0; popReq = 1'b0; flush = 1'b0;
        @(negedge clk);
        checkOutput("preReset p0Gnt", 96'(p0Gnt), 96'(1));
        @(posedge clk);
        #1;
        p1Req = 1'b1; p1Amt = 4'd5; popReq = 1'b1; popAmt = 4'd0;
        #2 rstn = 1'b0;
        @(negedge clk);
        checkAllZero("midReset");
        @(posedge clk);
        #1;
        checkAllZero("heldReset");
        popReq = 1'b0;
        rstn   = 1'b1;
        @(negedge clk);
        checkOutput("postReset p0Gnt", 96'(p0Gnt), 96'(1));
        checkOutput("postReset p1Gnt", 96'(p1Gnt), 96'(0));
        @(posedge clk);
        #1;
        checkOutput("postReset occ", 96'(occ), 96'(6));

        // Reset while draining: the flush is abandoned and never reports done.
        p0Req = 1'b0; p1Req = 1'b0; flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        #2 rstn = 1'b0;
        @(negedge clk);
        checkAllZero("flushReset");
        @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("afterFlushReset%0d done", i), 96'(flushDone), 96'(0));
            checkOutput($sformatf("afterFlushReset%0d popEn", i), 96'(popEn), 96'(0));
            checkOutput($sformatf("afterFlushReset%0d occ", i), 96'(occ), 96'(0));
        end
        @(posedge clk);
        #1;

        // Randomized traffic against the reference model; requests stay held until granted.
        mOcc = 0; mLast = 1; mPhase = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            int popN, nj, cand, drain, preOcc;
            bit run, ePop, eJoin, eDone;
            if (!p0Req && ($urandom_range(0, 2) == 0)) begin
                p0Req = 1'b1; p0Amt = 4'($urandom_range(0, 15));
            end
            if (!p1Req && ($urandom_range(0, 2) == 0)) begin
                p1Req = 1'b1; p1Amt = 4'($urandom_range(0, 15));
            end
            if (!popReq && ($urandom_range(0, 3) == 0)) begin
                popReq = 1'b1; popAmt = 4'($urandom_range(0, 15));
            end
            flush  = ($urandom_range(0, 49) == 0);
            p0Data = {$urandom, $urandom, $urandom};
            p1Data = {$urandom, $urandom, $urandom};

            popN = int'(popAmt) + 1;
            run  = (mPhase == 0) && !flush;
            ePop = run && popReq && (mOcc >= popN);
            if (p0Req && p1Req) cand = (mLast == 0) ? 1 : 0;
            else if (p0Req)     cand = 0;
            else if (p1Req)     cand = 1;
            else                cand = -1;
            nj    = (cand == 1) ? int'(p1Amt) + 1 : int'(p0Amt) + 1;
            eJoin = run && (cand >= 0) && (mOcc + nj - (ePop ? popN : 0) <= CAP_SYM);
            drain = (mPhase == 1) ? ((mOcc < MAX_SYM) ? mOcc : MAX_SYM) : 0;
            eDone = (mPhase == 2);

            @(negedge clk);
            checkOutput($sformatf("rand%0d p0Gnt", cyc), 96'(p0Gnt), 96'(eJoin && cand == 0));
            checkOutput($sformatf("rand%0d p1Gnt", cyc), 96'(p1Gnt), 96'(eJoin && cand == 1));
            checkOutput($sformatf("rand%0d popGnt", cyc), 96'(popGnt), 96'(ePop));
            checkOutput($sformatf("rand%0d flushDone", cyc), 96'(flushDone), 96'(eDone));
            expData    = !eJoin ? '0 : ((cand == 1) ? p1Data : p0Data);
            expJoinAmt = !eJoin ? 4'd0 : ((cand == 1) ? p1Amt : p0Amt);

            preOcc = mOcc;
            mOcc   = mOcc + (eJoin ? nj : 0) - (ePop ? popN : 0) - drain;
            if (eJoin) mLast = cand;
            if (mPhase == 0 && flush)       mPhase = 1;
            else if (mPhase == 1 && preOcc == 0) mPhase = 2;
            else if (mPhase == 2)           mPhase = 0;

            @(posedge clk);
            #1;
            checkOutput($sformatf("rand%0d joinEn", cyc), 96'(joinEn), 96'(eJoin));
            checkOutput($sformatf("rand%0d joinAmt", cyc), 96'(joinAmt), 96'(expJoinAmt));
            checkOutput($sformatf("rand%0d joinData", cyc), joinData, expData);
            checkOutput($sformatf("rand%0d popEn", cyc), 96'(popEn), 96'(ePop || drain > 0));
            checkOutput($sformatf("rand%0d popAmt", cyc), 96'(popAmtOut),
                        96'(ePop ? int'(popAmt) : (drain > 0 ? drain - 1 : 0)));
            checkOutput($sformatf("rand%0d occ", cyc), 96'(occ), 96'(mOcc));

            if (eJoin && cand == 0) p0Req = 1'b0;
            if (eJoin && cand == 1) p1Req = 1'b0;
            if (ePop) popReq = 1'b0;
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
